axis_uart_tx_cfg: RTL
=====================

Name: axis_uart_tx_cfg

Overview:
AXI-Stream to UART transmitter with a buffered input and frame format that is configurable at run time. Runs fully in the aclk domain; bit timing comes from a one-cycle uart_ena strobe supplied by the shared baud generator. An internal first-word-fall-through (FWFT) FIFO decouples bursty AXIS writers from the serial line. Back-to-back frames are sent with no idle gap. A line-break request is supported. Sits between the host/bus fabric and the txd pad.

Parameters:
DATA_BITS, 8, max data width; AXIS tdata width; legal 5..9
FIFO_DEPTH, 16, input FIFO entries; power of 2, >=2
FIFO_AW, clog2(FIFO_DEPTH), derived; not overridden

Ports:
aclk  in  1  clock
arstn  in  1  synchronous active-low reset
s_axis_tdata  in  DATA_BITS  byte to send, LSB first
s_axis_tvalid  in  1  AXIS valid
s_axis_tready  out  1  AXIS ready = !fifo_full & arstn
uart_ena  in  1  bit-rate strobe, one aclk pulse per bit period
cfg_data_bits  in  4  data bits per frame, 5..DATA_BITS
cfg_parity_ena  in  1  1 = insert parity bit
cfg_parity_type  in  2  0 even, 1 odd, 2 mark, 3 space
cfg_stop_bits  in  1  0 = 1 stop bit, 1 = 2 stop bits
tx_break  in  1  request to hold txd low
txd  out  1  serial output, idle high
tx_busy  out  1  frame in progress (state != IDLE)
fifo_count  out  FIFO_AW+1  entries held

Behaviour:
- Reset (arstn=0 at a rising aclk edge): txd=1, tx_busy=0, fifo_count=0, s_axis_tready=0, state=IDLE, FIFO pointers cleared. Reset mid-frame aborts the frame at once and discards FIFO contents.
- AXIS handshake: push when tvalid & tready. tready=0 only when the FIFO is full or in reset. When full, tvalid is held and the data is not lost. A push and a pop in the same cycle leave fifo_count unchanged.
- All txd changes happen only on edges where uart_ena=1. Every bit lasts exactly one strobe period. txd is registered and glitch-free.
- IDLE: on uart_ena, if the FIFO is not empty and tx_break=0:
  - pop the head,
  - latch the head into the shift register; latch cfg_* for the whole frame,
  - compute parity over data bits [cfg_data_bits-1:0] (upper bits masked),
  - txd<=0, go to START.
- IDLE with tx_break=1: txd<=0 on the next uart_ena and held low; returns to 1 on the first uart_ena after tx_break drops. No frame starts while a break is held.
- START, on uart_ena: txd<=d[0], bitcnt<=0, go to DATA.
- DATA, on uart_ena:
  - if bitcnt==cfg_data_bits-1: with parity enabled, txd<=parity and go to PARITY; otherwise txd<=1, stopcnt<=0, go to STOP.
  - else: txd<=d[bitcnt+1], bitcnt++.
- PARITY, on uart_ena: txd<=1, stopcnt<=0, go to STOP.
- STOP, on uart_ena:
  - if stopcnt==number of stop bits minus 1: if the FIFO is not empty and tx_break=0, pop, txd<=0, go to START (back-to-back); else txd<=1, go to IDLE.
  - else stopcnt++.
- Parity values: even = ^d; odd = ~^d; mark = 1; space = 0.
- cfg clamping: cfg_data_bits <5 clamps to 5; >DATA_BITS clamps to DATA_BITS.
- cfg changes mid-frame take effect at the next frame only.
- tx_break asserted mid-frame takes effect after the current stop bit(s).
- Frame length = 1 + N + P + S strobes. First start-bit edge follows the first uart_ena after data is available (>=1 cycle after the push).

Decomposition:
- Package axis_uart_pkg:
  - state encoding IDLE/START/DATA/PARITY/STOP,
  - parity-type constants PAR_EVEN/ODD/MARK/SPACE,
  - min data bits constant (5).
- One sub-module: axis_uart_fifo_fwft (single-clock FWFT FIFO with full/empty/count), reusable by a matching RX block.

Test Plan:
- 8N1, push 0xA5, uart_ena every 4 cycles -> txd across strobes = 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); tx_busy high for exactly 10 strobe periods.
- 7E2, push 0x41 -> 7 data bits 1000001, parity 0, then two stop bits; next byte 0x03 (odd parity, 8O1 after a cfg change between frames) -> parity bit 1.
- Fill FIFO with 17 pushes while uart_ena=0 -> tready drops after 16, fifo_count=16; enable strobes -> 16 frames sent back-to-back with no idle strobe between stop and start, then tready returns high.
- Mark/space: 8M1 with 0x00 -> parity bit 1; 8S1 with 0xFF -> parity bit 0.
- tx_break asserted during frame 1 of 2 queued -> frame 1 completes, txd low from the next strobe, frame 2 starts on the first strobe after the break is released.
- arstn pulsed low mid-DATA with 3 entries queued -> next cycle txd=1, fifo_count=0, tx_busy=0; no partial frame resumes.

Source files
------------

// File: rtl/axis_uart_pkg.sv
// Shared types and constants for the AXI-Stream UART blocks.
// The state encoding and parity codes are common to TX and RX.
package axis_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_EVEN  = 2'd0;
    localparam logic [1:0] PAR_ODD   = 2'd1;
    localparam logic [1:0] PAR_MARK  = 2'd2;
    localparam logic [1:0] PAR_SPACE = 2'd3;

    localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/axis_uart_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// The head word is always visible on rdata_o while empty_o is low.
module axis_uart_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two, so the count MSB alone marks full
    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                count_q <= count_q + 1'b1;
            else if (do_pop && !do_push)
                count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axis_uart_tx_cfg.sv
// AXI-Stream to UART transmitter with buffered input and a frame
// format (data bits, parity, stop bits) latched per frame.
module axis_uart_tx_cfg
    import axis_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic                 aclk,
    input  logic                 arstn,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 uart_ena,
    input  logic [3:0]           cfg_data_bits,
    input  logic                 cfg_parity_ena,
    input  logic [1:0]           cfg_parity_type,
    input  logic                 cfg_stop_bits,
    input  logic                 tx_break,
    output logic                 txd,
    output logic                 tx_busy,
    output logic [FIFO_AW:0]     fifo_count
);

    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        logic [3:0] r;
        r = n;
        if (n < 4'(MIN_DATA_BITS)) r = 4'(MIN_DATA_BITS);
        if (n > 4'(DATA_BITS))     r = 4'(DATA_BITS);
        return r;
    endfunction

    function automatic logic calc_parity(
        input logic [DATA_BITS-1:0] d,
        input logic [3:0]           n,
        input logic [1:0]           t
    );
        logic x;
        logic r;
        x = 1'b0;
        for (int i = 0; i < DATA_BITS; i++)
            if (i < int'(n)) x ^= d[i];
        case (t)
            PAR_EVEN: r = x;
            PAR_ODD:  r = ~x;
            PAR_MARK: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 frame_ok;
    logic [3:0]           nbits_new;

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           nbits_q, nbits_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic                 par_ena_q, par_ena_d;
    logic                 par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic                 stopcnt_q, stopcnt_d;
    logic                 txd_q, txd_d;

    assign s_axis_tready = ~fifo_full & arstn;
    assign fifo_push     = s_axis_tvalid & s_axis_tready;
    assign txd           = txd_q;
    assign tx_busy       = (state_q != ST_IDLE);
    assign frame_ok      = ~fifo_empty & ~tx_break;
    assign nbits_new     = clamp_bits(cfg_data_bits);

    axis_uart_fifo_fwft #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i   (aclk),
        .rst_ni  (arstn),
        .push_i  (fifo_push),
        .wdata_i (s_axis_tdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        nbits_d   = nbits_q;
        bitcnt_d  = bitcnt_q;
        par_ena_d = par_ena_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        stopcnt_d = stopcnt_q;
        txd_d     = txd_q;
        fifo_pop  = 1'b0;
        if (uart_ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_ok) begin
                        fifo_pop = 1'b1;
                        txd_d    = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        txd_d = ~tx_break;
                    end
                end
                ST_START: begin
                    txd_d    = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    if (bitcnt_q == nbits_q - 4'd1) begin
                        if (par_ena_q) begin
                            txd_d   = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d     = 1'b1;
                            stopcnt_d = 1'b0;
                            state_d   = ST_STOP;
                        end
                    end else begin
                        txd_d    = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    txd_d     = 1'b1;
                    stopcnt_d = 1'b0;
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    if (stopcnt_q == stop2_q) begin
                        // Chain straight into the next start bit when data waits
                        if (frame_ok) begin
                            fifo_pop = 1'b1;
                            txd_d    = 1'b0;
                            state_d  = ST_START;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stopcnt_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (fifo_pop) begin
            shreg_d   = fifo_rdata;
            nbits_d   = nbits_new;
            par_ena_d = cfg_parity_ena;
            par_d     = calc_parity(fifo_rdata, nbits_new, cfg_parity_type);
            stop2_d   = cfg_stop_bits;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            nbits_q   <= 4'(DATA_BITS);
            bitcnt_q  <= '0;
            par_ena_q <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            stopcnt_q <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            nbits_q   <= nbits_d;
            bitcnt_q  <= bitcnt_d;
            par_ena_q <= par_ena_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            stopcnt_q <= stopcnt_d;
            txd_q     <= txd_d;
        end
    end

endmodule
